// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART frame sequencer.
//   - seq_state_t : sequencer FSM states
//   - CHAR_*      : ASCII bytes used in the "A+B=SS[CR LF]" frame
//   - FRAME_LEN_* : frame lengths without / with the CR LF trailer
package uart_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_NEXT      = 3'd5
  } seq_state_t;

  localparam logic [7:0] CHAR_PLUS = 8'h2B;
  localparam logic [7:0] CHAR_EQ   = 8'h3D;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_0    = 8'h30;

  localparam int FRAME_LEN_SHORT = 6;
  localparam int FRAME_LEN_CRLF  = 8;

endpackage

// File: rtl/hex_to_ascii.sv
// Converts a 4-bit nibble to its ASCII hex digit.
// Ports:
//   nibble : value 0..15
//   ascii  : '0'..'9', then 'A'..'F' (HEX_UPPER=1) or 'a'..'f' (HEX_UPPER=0)
module hex_to_ascii
  import uart_seq_pkg::*;
#(
  parameter bit HEX_UPPER = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  localparam logic [7:0] ALPHA_BASE = HEX_UPPER ? 8'h41 : 8'h61;

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = CHAR_0 + {4'b0000, nibble};
    end else begin
      ascii = ALPHA_BASE + {4'b0000, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_frame_sequencer.sv
// Sequences the shared UART transmitter: on a send request it snapshots
// op_a, op_b and sum and emits "A+B=SS" (plus CR LF when SEND_CRLF=1),
// one byte per tx_start.
//
// Handshake: tx_start is a one-cycle pulse with tx_data valid in the same
// cycle. The TX core acknowledges by raising tx_busy; the byte is complete
// when tx_busy falls again. If tx_busy does not rise within ACK_TIMEOUT
// cycles of tx_start, ack_err is set (sticky) and the byte counts as sent.
//
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   op_a, op_b, sum   : operands and their sum (sampled on request accept)
//   send_req          : frame request, level or pulse
//   tx_busy           : UART TX busy
//   tx_start, tx_data : byte launch to the UART TX
//   seq_busy          : frame in progress
//   frame_done        : one-cycle pulse after the last byte completes
//   ack_err           : sticky acknowledge timeout flag
//   dbg_state         : current FSM state (seq_state_t encoding)
module uart_frame_sequencer
  import uart_seq_pkg::*;
#(
  parameter bit SEND_CRLF   = 1'b1,
  parameter bit HEX_UPPER   = 1'b1,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  input  logic [4:0] sum,
  input  logic       send_req,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       seq_busy,
  output logic       frame_done,
  output logic       ack_err,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] LAST_IDX =
    SEND_CRLF ? 3'(FRAME_LEN_CRLF - 1) : 3'(FRAME_LEN_SHORT - 1);
  localparam logic [3:0] ACK_LAST = 4'(ACK_TIMEOUT - 1);

  seq_state_t state, state_nxt;
  logic [2:0] idx;
  logic       pending;
  logic [3:0] a_q, b_q;
  logic [4:0] s_q;
  logic [3:0] ack_cnt;

  logic       accept;
  logic       ack_expired;
  logic       frame_end;
  logic [3:0] nibble;
  logic [7:0] hex_byte;
  logic [7:0] load_byte;

  assign dbg_state = state;

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    ack_expired = 1'b0;
    frame_end   = 1'b0;
    case (state)
      ST_IDLE: begin
        // A foreign byte in flight blocks the start; the request stays
        // remembered in pending until tx_busy drops.
        if ((send_req || pending) && !tx_busy) begin
          accept    = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:  state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          ack_expired = 1'b1;
          state_nxt   = ST_NEXT;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx == LAST_IDX) begin
          frame_end = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Single converter shared by all hex positions; the nibble is chosen by index.
  always_comb begin
    nibble = 4'h0;
    case (idx)
      3'd0:    nibble = a_q;
      3'd2:    nibble = b_q;
      3'd4:    nibble = {3'b000, s_q[4]};
      3'd5:    nibble = s_q[3:0];
      default: nibble = 4'h0;
    endcase
  end

  hex_to_ascii #(
    .HEX_UPPER(HEX_UPPER)
  ) u_hex (
    .nibble(nibble),
    .ascii (hex_byte)
  );

  always_comb begin
    load_byte = hex_byte;
    case (idx)
      3'd1:    load_byte = CHAR_PLUS;
      3'd3:    load_byte = CHAR_EQ;
      3'd6:    load_byte = CHAR_CR;
      3'd7:    load_byte = CHAR_LF;
      default: load_byte = hex_byte;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= 3'd0;
      pending    <= 1'b0;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      s_q        <= 5'h00;
      ack_cnt    <= 4'h0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      seq_busy   <= 1'b0;
      frame_done <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      // Registered from next state so seq_busy tracks (state != IDLE) exactly.
      seq_busy   <= (state_nxt != ST_IDLE);
      tx_start   <= (state == ST_START);
      frame_done <= frame_end;

      // One-deep request memory; repeated requests merge.
      pending <= accept ? 1'b0 : (pending | send_req);

      if (accept) begin
        a_q <= op_a;
        b_q <= op_b;
        s_q <= sum;
      end

      if (state == ST_LOAD) begin
        tx_data <= load_byte;
      end

      if (state == ST_START) begin
        ack_cnt <= 4'h0;
      end else if (state == ST_WAIT_ACK) begin
        ack_cnt <= ack_cnt + 4'd1;
      end

      if (ack_expired) begin
        ack_err <= 1'b1;
      end

      if (state == ST_NEXT) begin
        idx <= frame_end ? 3'd0 : idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer. Two instances: dut_u (upper hex, CR LF)
// and dut_l (lower hex, no CR LF), each with a simple UART TX model.
module tb_uart_frame_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_u, rst_n_l;
  logic [3:0] op_a_u, op_b_u, op_a_l, op_b_l;
  logic [4:0] sum_u, sum_l;
  logic       send_req_u, send_req_l;
  logic       tx_busy_u, tx_busy_l;
  logic       tx_start_u, tx_start_l;
  logic [7:0] tx_data_u, tx_data_l;
  logic       seq_busy_u, seq_busy_l;
  logic       frame_done_u, frame_done_l;
  logic       ack_err_u, ack_err_l;
  logic [2:0] dbg_state_u, dbg_state_l;

  uart_frame_sequencer dut_u (
    .clk(clk), .reset_n(rst_n_u), .op_a(op_a_u), .op_b(op_b_u), .sum(sum_u),
    .send_req(send_req_u), .tx_busy(tx_busy_u), .tx_start(tx_start_u),
    .tx_data(tx_data_u), .seq_busy(seq_busy_u), .frame_done(frame_done_u),
    .ack_err(ack_err_u), .dbg_state(dbg_state_u)
  );

  uart_frame_sequencer #(
    .SEND_CRLF(1'b0), .HEX_UPPER(1'b0), .ACK_TIMEOUT(4)
  ) dut_l (
    .clk(clk), .reset_n(rst_n_l), .op_a(op_a_l), .op_b(op_b_l), .sum(sum_l),
    .send_req(send_req_l), .tx_busy(tx_busy_l), .tx_start(tx_start_l),
    .tx_data(tx_data_l), .seq_busy(seq_busy_l), .frame_done(frame_done_l),
    .ack_err(ack_err_l), .dbg_state(dbg_state_l)
  );

  // ---------------- UART TX models ----------------
  // busy rises the cycle after tx_start and stays high for 10 cycles.
  logic       busy_u = 1'b0, busy_l = 1'b0;
  logic [3:0] bcnt_u = 4'd0, bcnt_l = 4'd0;
  logic       force_busy_u = 1'b0;
  logic       stuck_l = 1'b0;

  assign tx_busy_u = busy_u | force_busy_u;
  assign tx_busy_l = busy_l;

  always @(posedge clk) begin
    if (bcnt_u != 4'd0) begin
      bcnt_u <= bcnt_u - 4'd1;
      if (bcnt_u == 4'd1) busy_u <= 1'b0;
    end else if (tx_start_u) begin
      busy_u <= 1'b1;
      bcnt_u <= 4'd10;
    end
  end

  always @(posedge clk) begin
    if (stuck_l) begin
      busy_l <= 1'b0;
      bcnt_l <= 4'd0;
    end else if (bcnt_l != 4'd0) begin
      bcnt_l <= bcnt_l - 4'd1;
      if (bcnt_l == 4'd1) busy_l <= 1'b0;
    end else if (tx_start_l) begin
      busy_l <= 1'b1;
      bcnt_l <= 4'd10;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] exp_q_u[$];
  logic [7:0] exp_q_l[$];
  int starts_u = 0, starts_l = 0, fd_u = 0, fd_l = 0;
  int st_cyc_l[$];

  typedef struct packed {
    logic [3:0]  a;
    logic [3:0]  b;
    logic [4:0]  s;
    logic [63:0] bytes;
  } vec_t;

  vec_t vu[4];
  vec_t vl[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance one cycle; all output sampling happens here on the falling edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (tx_start_u === 1'b1) begin
      starts_u++;
      if (exp_q_u.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u_extra_byte: got tx_data 0x%0h, want no tx_start", tx_data_u);
      end else begin
        e = exp_q_u.pop_front();
        check("u_byte", tx_data_u, e);
      end
    end
    if (tx_start_l === 1'b1) begin
      starts_l++;
      st_cyc_l.push_back(cyc);
      if (exp_q_l.size() == 0) begin
        total++;
        bad++;
        $display("FAIL l_extra_byte: got tx_data 0x%0h, want no tx_start", tx_data_l);
      end else begin
        e = exp_q_l.pop_front();
        check("l_byte", tx_data_l, e);
      end
    end
    if (frame_done_u === 1'b1) fd_u++;
    if (frame_done_l === 1'b1) fd_l++;
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit upper);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (upper ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  function automatic logic [63:0] frame_model(input logic [3:0] a, input logic [3:0] b,
                                              input logic [4:0] s, input bit upper);
    return {hexc(a, upper), 8'h2B, hexc(b, upper), 8'h3D,
            hexc({3'b000, s[4]}, upper), hexc(s[3:0], upper), 8'h0D, 8'h0A};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_exp(input bit sel, input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) exp_q_l.push_back(bytes[63-8*i -: 8]);
      else     exp_q_u.push_back(bytes[63-8*i -: 8]);
    end
  endtask

  task automatic pulse_send(input bit sel);
    if (sel) send_req_l = 1'b1; else send_req_u = 1'b1;
    tick();
    send_req_l = 1'b0;
    send_req_u = 1'b0;
  endtask

  task automatic wait_fd(input bit sel, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (((sel ? fd_l : fd_u) < target) && n < budget) begin
      tick();
      n++;
    end
    check(name, sel ? fd_l : fd_u, target);
  endtask

  task automatic run_frame(input bit sel, input logic [3:0] a, input logic [3:0] b,
                           input logic [4:0] s, input logic [63:0] bytes, input string name);
    int base;
    int n;
    n = sel ? 6 : 8;
    base = sel ? fd_l : fd_u;
    if (sel) begin op_a_l = a; op_b_l = b; sum_l = s; end
    else     begin op_a_u = a; op_b_u = b; sum_u = s; end
    push_exp(sel, bytes, n);
    pulse_send(sel);
    wait_fd(sel, base + 1, 400, {name, "_done"});
    check({name, "_seq_busy"}, sel ? seq_busy_l : seq_busy_u, 1'b0);
    check({name, "_left"}, sel ? exp_q_l.size() : exp_q_u.size(), 0);
    tick();
    check({name, "_one_pulse"}, sel ? fd_l : fd_u, base + 1);
  endtask

  // ---------------- test ----------------
  initial begin
    int base;
    int n;
    logic [3:0] ra, rb;

    vu[0] = '{4'h7, 4'h9, 5'd16, 64'h37_2B_39_3D_31_30_0D_0A};
    vu[1] = '{4'h0, 4'h0, 5'd0,  64'h30_2B_30_3D_30_30_0D_0A};
    vu[2] = '{4'hF, 4'hA, 5'd25, 64'h46_2B_41_3D_31_39_0D_0A};
    vu[3] = '{4'hC, 4'h3, 5'd15, 64'h43_2B_33_3D_30_46_0D_0A};
    vl[0] = '{4'hF, 4'hF, 5'd30, 64'h66_2B_66_3D_31_65_00_00};
    vl[1] = '{4'hA, 4'hB, 5'd21, 64'h61_2B_62_3D_31_35_00_00};
    vl[2] = '{4'h9, 4'hE, 5'd23, 64'h39_2B_65_3D_31_37_00_00};

    rst_n_u = 1'b0; rst_n_l = 1'b0;
    send_req_u = 1'b0; send_req_l = 1'b0;
    op_a_u = 4'h0; op_b_u = 4'h0; sum_u = 5'd0;
    op_a_l = 4'h0; op_b_l = 4'h0; sum_l = 5'd0;
    repeat (3) tick();
    check("u_reset_outs", {tx_start_u, tx_data_u, seq_busy_u, frame_done_u, ack_err_u, dbg_state_u}, 0);
    check("l_reset_outs", {tx_start_l, tx_data_l, seq_busy_l, frame_done_l, ack_err_l, dbg_state_l}, 0);
    rst_n_u = 1'b1; rst_n_l = 1'b1;
    repeat (2) tick();

    // Request-to-tx_start latency is three cycles.
    op_a_u = 4'h7; op_b_u = 4'h9; sum_u = 5'd16;
    push_exp(1'b0, vu[0].bytes, 8);
    base = starts_u;
    pulse_send(1'b0);
    check("u_seq_busy_set", seq_busy_u, 1'b1);
    tick();
    check("u_latency_early", starts_u, base);
    tick();
    check("u_latency", starts_u, base + 1);
    wait_fd(1'b0, 1, 400, "u_first_done");
    check("u_first_idle", seq_busy_u, 1'b0);

    // Table frames
    for (int i = 0; i < 4; i++) run_frame(1'b0, vu[i].a, vu[i].b, vu[i].s, vu[i].bytes, "u_tab");
    for (int i = 0; i < 3; i++) run_frame(1'b1, vl[i].a, vl[i].b, vl[i].s, vl[i].bytes, "l_tab");
    check("l_ack_err_clean", ack_err_l, 1'b0);
    check("u_ack_err_clean", ack_err_u, 1'b0);

    // Random frames against the model
    for (int i = 0; i < 4; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      run_frame(1'b0, ra, rb, 5'(ra) + 5'(rb), frame_model(ra, rb, 5'(ra) + 5'(rb), 1'b1), "u_rand");
    end

    // Snapshot isolation plus a request merged during the frame
    base = fd_u;
    op_a_u = 4'h3; op_b_u = 4'h4; sum_u = 5'd7;
    push_exp(1'b0, frame_model(4'h3, 4'h4, 5'd7, 1'b1), 8);
    pulse_send(1'b0);
    n = 0;
    while (exp_q_u.size() > 7 && n < 50) begin tick(); n++; end
    check("u_snap_first_byte", exp_q_u.size(), 7);
    op_a_u = 4'h2; sum_u = 5'd6;
    push_exp(1'b0, frame_model(4'h2, 4'h4, 5'd6, 1'b1), 8);
    pulse_send(1'b0);
    wait_fd(1'b0, base + 2, 700, "u_snap_two_frames");
    check("u_snap_left", exp_q_u.size(), 0);

    // Reset in the middle of byte 3
    op_a_u = 4'h1; op_b_u = 4'h1; sum_u = 5'd2;
    push_exp(1'b0, frame_model(4'h1, 4'h1, 5'd2, 1'b1), 8);
    pulse_send(1'b0);
    n = 0;
    while (exp_q_u.size() > 4 && n < 200) begin tick(); n++; end
    check("u_rst_reached_b3", exp_q_u.size(), 4);
    rst_n_u = 1'b0;
    #1;
    check("u_rst_async_outs", {tx_start_u, tx_data_u, seq_busy_u, frame_done_u, ack_err_u, dbg_state_u}, 0);
    exp_q_u.delete();
    base = starts_u;
    repeat (2) tick();
    rst_n_u = 1'b1;
    repeat (40) tick();
    check("u_rst_no_start", starts_u, base);
    check("u_rst_idle", seq_busy_u, 1'b0);
    run_frame(1'b0, 4'h8, 4'h2, 5'd10, frame_model(4'h8, 4'h2, 5'd10, 1'b1), "u_post_rst");

    // Start gating behind a foreign busy
    force_busy_u = 1'b1;
    op_a_u = 4'h5; op_b_u = 4'h6; sum_u = 5'd11;
    push_exp(1'b0, frame_model(4'h5, 4'h6, 5'd11, 1'b1), 8);
    base = starts_u;
    pulse_send(1'b0);
    repeat (8) tick();
    check("u_gate_held", starts_u, base);
    check("u_gate_idle", seq_busy_u, 1'b0);
    force_busy_u = 1'b0;
    repeat (2) tick();
    check("u_gate_early", starts_u, base);
    tick();
    check("u_gate_latency", starts_u, base + 1);
    wait_fd(1'b0, fd_u + 1, 400, "u_gate_done");
    check("u_gate_left", exp_q_u.size(), 0);

    // Acknowledge timeout on dut_l
    stuck_l = 1'b1;
    st_cyc_l.delete();
    run_frame(1'b1, 4'h1, 4'h2, 5'd3, 64'h31_2B_32_3D_30_33_00_00, "l_tmo");
    check("l_tmo_starts", st_cyc_l.size(), 6);
    for (int i = 1; i < 6 && i < st_cyc_l.size(); i++)
      check("l_tmo_spacing", st_cyc_l[i] - st_cyc_l[i-1], 7);
    check("l_ack_err_set", ack_err_l, 1'b1);
    stuck_l = 1'b0;
    repeat (2) tick();
    run_frame(1'b1, vl[1].a, vl[1].b, vl[1].s, vl[1].bytes, "l_after_tmo");
    check("l_ack_err_sticky", ack_err_l, 1'b1);

    repeat (5) tick();
    check("u_final_left", exp_q_u.size(), 0);
    check("l_final_left", exp_q_l.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
